// File: rtl/init_seq_pkg.sv
// Shared definitions for the power-up sequencer: FSM state encoding and default counter width.
package init_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/init_seq_if.sv
// Control/status bundle of the power-up sequencer.
// master: the surrounding system (drives lock and re-init requests).
// slave:  the sequencer itself (drives strobes, pulses and status).
interface init_seq_if #(
    parameter int N_UART = 2,
    parameter int N_CH   = 4
);
    logic                   locked;
    logic                   reinit;
    logic [N_UART-1:0]      latch_baud;
    logic [16*N_UART-1:0]   baud_word;
    logic [N_CH-1:0]        init_pulse;
    logic                   busy;
    logic                   done;
    logic                   lock_err;

    modport master (
        output locked, reinit,
        input  latch_baud, baud_word, init_pulse, busy, done, lock_err
    );

    modport slave (
        input  locked, reinit,
        output latch_baud, baud_word, init_pulse, busy, done, lock_err
    );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for slow level signals crossing into clk.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; both stages clear to 0 on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/init_seq.sv
// Power-up sequencer: after PLL lock runs one timed sequence producing baud-latch
// strobes, per-channel init pulses and a done level. Lock loss aborts (sticky
// lock_err), reinit restarts. All outputs are registered.
module init_seq
    import init_seq_pkg::*;
#(
    parameter int                       CNT_W     = CNT_W_DEF,
    parameter int                       WAIT_LEN  = 200,
    parameter int                       N_UART    = 2,
    parameter int                       BAUD_ST   = 100,
    parameter logic [16*N_UART-1:0]     BAUD_SET  = {N_UART{16'd2}},
    parameter int                       N_CH      = 4,
    parameter logic [CNT_W*N_CH-1:0]    PULSE_ST  = {N_CH{CNT_W'(4)}},
    parameter logic [CNT_W*N_CH-1:0]    PULSE_LEN = {N_CH{CNT_W'(1)}}
) (
    input  logic      clk,
    input  logic      rst,
    init_seq_if.slave bus
);
    logic              locked_s;
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_UART-1:0] latch_q;
    logic [N_CH-1:0]   pulse_q;
    logic              busy_q;
    logic              done_q;
    logic              lock_err_q;
    logic              at_end;
    logic              at_baud;
    logic [N_CH-1:0]   win;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (bus.locked),
        .q_o   (locked_s)
    );

    assign at_end  = (cnt_q == CNT_W'(WAIT_LEN));
    assign at_baud = (cnt_q == CNT_W'(BAUD_ST));

    // Per-channel window: ST <= cnt < ST+LEN, end computed one bit wider so it cannot wrap.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] st_k;
        logic [CNT_W-1:0] len_k;
        logic [CNT_W:0]   end_k;
        assign st_k    = PULSE_ST[gi*CNT_W +: CNT_W];
        assign len_k   = PULSE_LEN[gi*CNT_W +: CNT_W];
        assign end_k   = {1'b0, st_k} + {1'b0, len_k};
        assign win[gi] = (cnt_q >= st_k) && ({1'b0, cnt_q} < end_k);
    end

    // Sequencer FSM; strobes and pulses are only produced while staying in RUN,
    // so any exit (abort, restart, completion) truncates them on the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            latch_q    <= '0;
            pulse_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            latch_q <= '0;
            pulse_q <= '0;
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    done_q <= 1'b0;
                    if (locked_s) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                        lock_err_q <= 1'b1;
                    end else if (bus.reinit) begin
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        lock_err_q <= 1'b0;
                    end else if (at_end) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        latch_q <= {N_UART{at_baud}};
                        pulse_q <= win;
                    end
                end
                DONE: begin
                    if (!locked_s) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                        lock_err_q <= 1'b1;
                    end else if (bus.reinit) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        lock_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.latch_baud = latch_q;
    assign bus.baud_word  = BAUD_SET;
    assign bus.init_pulse = pulse_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.lock_err   = lock_err_q;
endmodule
